// File: rtl/synth_voice_mixer_if.sv
// FIFO write side and SoC configuration port of the voice mixer.
// The mixer uses master; the FIFO/SoC side uses slave.
interface synth_voice_mixer_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
);
  logic                          LD_FIFO;
  logic [31:0]                   TONE;
  logic                          FIFO_FULL;
  logic                          CFG_WE;
  logic [$clog2(NUM_VOICES)-1:0] CFG_VOICE;
  logic [1:0]                    CFG_SEL;
  logic [PHASE_W-1:0]            CFG_DATA;

  modport master (
    output LD_FIFO, TONE,
    input  FIFO_FULL, CFG_WE, CFG_VOICE, CFG_SEL, CFG_DATA
  );

  modport slave (
    input  LD_FIFO, TONE,
    output FIFO_FULL, CFG_WE, CFG_VOICE, CFG_SEL, CFG_DATA
  );
endinterface

// File: rtl/synth_voice_mixer.sv
// Multi-voice oscillator mixer: renders one voice per cycle, saturates the sum
// and pushes a {L,R} stereo word into the audio sample FIFO.
module synth_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                RUN,
  synth_voice_mixer_if.master bus
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int AW = 16 + VW;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] SAT   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;

  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = -(AW'(32768));

  logic [2:0]              state;
  logic [VW-1:0]           vidx;
  logic signed [AW-1:0]    acc;
  logic [31:0]             tone;
  logic [PHASE_W-1:0]      phase [NUM_VOICES];
  logic [PHASE_W-1:0]      inc   [NUM_VOICES];
  logic [7:0]              amp   [NUM_VOICES];
  logic [1:0]              wave  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate;

  logic signed [15:0]      c_raw;
  logic signed [15:0]      c_gated;
  logic signed [AW-1:0]    c_ext;
  logic signed [15:0]      sample;

  function automatic logic signed [15:0] contribution(input logic [1:0] w,
                                                      input logic [7:0] a,
                                                      input logic [8:0] p);
    logic signed [15:0] sq;
    logic signed [7:0]  s;
    logic signed [16:0] prod;
    sq = $signed({1'b0, a, 7'b0});
    case (w)
      2'd1:    s = $signed({~p[8], p[7:1]});
      2'd2:    s = $signed((p[8] ? ~p[7:0] : p[7:0]) ^ 8'h80);
      default: s = '0;
    endcase
    prod = s * $signed({1'b0, a});
    if (w == 2'd0) return p[8] ? -sq : sq;
    return prod[15:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [AW-1:0] a);
    if (a > SAT_MAX) return 16'sh7fff;
    if (a < SAT_MIN) return 16'sh8000;
    return a[15:0];
  endfunction

  // Contribution is taken from the phase before this cycle's update
  assign c_raw   = contribution(wave[vidx], amp[vidx], phase[vidx][PHASE_W-1 -: 9]);
  assign c_gated = gate[vidx] ? c_raw : 16'sd0;
  assign c_ext   = {{VW{c_gated[15]}}, c_gated};
  assign sample  = sat16(acc);

  assign bus.LD_FIFO = (state == PUSH);
  assign bus.TONE    = tone;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      vidx  <= '0;
      acc   <= '0;
      tone  <= '0;
      gate  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
        amp[i]   <= '0;
        wave[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          acc  <= '0;
          vidx <= '0;
          if (RUN) state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc + c_ext;
          if (gate[vidx]) phase[vidx] <= phase[vidx] + inc[vidx];
          if (vidx == VW'(NUM_VOICES - 1)) state <= SAT;
          else                              vidx  <= vidx + 1'b1;
        end
        SAT: begin
          tone  <= {sample, sample};
          state <= WAIT;
        end
        WAIT: begin
          if (!bus.FIFO_FULL) state <= PUSH;
        end
        PUSH: begin
          acc   <= '0;
          vidx  <= '0;
          state <= RUN ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase

      // Config writes come last so a phase clear overrides the accumulate update
      if (bus.CFG_WE) begin
        case (bus.CFG_SEL)
          2'd0: inc[bus.CFG_VOICE]  <= bus.CFG_DATA;
          2'd1: amp[bus.CFG_VOICE]  <= bus.CFG_DATA[7:0];
          2'd2: wave[bus.CFG_VOICE] <= bus.CFG_DATA[1:0];
          default: begin
            gate[bus.CFG_VOICE] <= bus.CFG_DATA[0];
            if (bus.CFG_DATA[1]) phase[bus.CFG_VOICE] <= '0;
          end
        endcase
      end
    end
  end
endmodule
